global_buffer_datapath: RTL and testbench

Datapath for the global buffer that the global PE-array controller drives. It holds the global SRAM with its read and write address counters, plus the PE-index and filter-number counters. It produces the status flags the controller branches on: end_read, last_PE and last_filter. It also carries the data path in both directions: filter/ifmap words out to the PE scratchpads, and final psums back from the last PE.

---
 rtl/global_buffer_datapath.sv | 115 +++++++++++
 tb/tb_global_buffer_datapath.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/global_buffer_datapath.sv
// Global buffer datapath: SRAM with read/write address counters, PE-index and
// filter counters, and the status flags the global PE-array controller branches on.
module global_buffer_datapath #(
    parameter int unsigned N          = 5,
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned DEPTH      = 256,
    parameter int unsigned READ_LAST  = 127,
    parameter int unsigned WRITE_BASE = 128,
    parameter int unsigned FILTERS    = 3,
    localparam int unsigned N_ADDR    = (N > 1) ? $clog2(N) : 1,
    localparam int unsigned ADDR_W    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              host_wen,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    input  logic              ren_global,
    input  logic              wen_global,
    input  logic              read_addr_en,
    input  logic              read_addr_clr,
    input  logic              write_addr_ld,
    input  logic              write_addr_en,
    input  logic              PE_number_en,
    input  logic              PE_number_clr,
    input  logic              filter_number_en,
    input  logic              filter_number_clr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    output logic              end_read,
    output logic [N_ADDR-1:0] PE_index,
    output logic              last_PE,
    output logic              last_filter,
    output logic              wr_overflow
);

    localparam int unsigned FILT_W = (FILTERS > 1) ? $clog2(FILTERS) : 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] read_addr;
    logic [ADDR_W-1:0] write_addr;
    logic [FILT_W-1:0] filter_cnt;

    // SRAM write port; controller psum write wins over host preload, nothing lands during reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (wen_global) begin
                mem[write_addr] <= wdata;
            end else if (host_wen) begin
                mem[host_addr] <= host_wdata;
            end
        end
    end

    // Registered read port; read-first because the array update above is non-blocking
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata  <= '0;
            rvalid <= 1'b0;
        end else begin
            rvalid <= ren_global;
            if (ren_global) begin
                rdata <= mem[read_addr];
            end
        end
    end

    // Read address saturates at the end of the filter/ifmap region
    always_ff @(posedge clk) begin
        if (rst || read_addr_clr) begin
            read_addr <= '0;
        end else if (read_addr_en && !end_read) begin
            read_addr <= read_addr + ADDR_W'(1);
        end
    end

    // Psum write address; an increment at the top of the SRAM holds and flags overflow
    always_ff @(posedge clk) begin
        if (rst) begin
            write_addr  <= ADDR_W'(WRITE_BASE);
            wr_overflow <= 1'b0;
        end else if (write_addr_ld) begin
            write_addr <= ADDR_W'(WRITE_BASE);
        end else if (write_addr_en) begin
            if (write_addr == ADDR_W'(DEPTH - 1)) begin
                wr_overflow <= 1'b1;
            end else begin
                write_addr <= write_addr + ADDR_W'(1);
            end
        end
    end

    // PE index and filter count wrap at their own moduli, not at a power of two
    always_ff @(posedge clk) begin
        if (rst || PE_number_clr) begin
            PE_index <= '0;
        end else if (PE_number_en) begin
            PE_index <= last_PE ? '0 : PE_index + N_ADDR'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || filter_number_clr) begin
            filter_cnt <= '0;
        end else if (filter_number_en) begin
            filter_cnt <= last_filter ? '0 : filter_cnt + FILT_W'(1);
        end
    end

    assign end_read    = (read_addr == ADDR_W'(READ_LAST));
    assign last_PE     = (PE_index == N_ADDR'(N - 1));
    assign last_filter = (filter_cnt == FILT_W'(FILTERS - 1));

endmodule

// File: tb/tb_global_buffer_datapath.sv
// Self-checking bench for global_buffer_datapath: directed scenarios plus
// randomized control traffic against a behavioural model of the buffer.
module tb_global_buffer_datapath;

    logic        clk = 1'b0;
    logic        rst;
    logic        host_wen;
    logic [7:0]  host_addr;
    logic [15:0] host_wdata;
    logic        ren_global, wen_global;
    logic        read_addr_en, read_addr_clr;
    logic        write_addr_ld, write_addr_en;
    logic        PE_number_en, PE_number_clr;
    logic        filter_number_en, filter_number_clr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        rvalid, end_read, last_PE, last_filter, wr_overflow;
    logic [2:0]  PE_index;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    logic [15:0] m_mem [256];
    int m_ra, m_wa, m_pe, m_filt;
    logic [15:0] m_rdata;
    logic m_rvalid, m_ovf;

    global_buffer_datapath dut (
        .clk(clk), .rst(rst),
        .host_wen(host_wen), .host_addr(host_addr), .host_wdata(host_wdata),
        .ren_global(ren_global), .wen_global(wen_global),
        .read_addr_en(read_addr_en), .read_addr_clr(read_addr_clr),
        .write_addr_ld(write_addr_ld), .write_addr_en(write_addr_en),
        .PE_number_en(PE_number_en), .PE_number_clr(PE_number_clr),
        .filter_number_en(filter_number_en), .filter_number_clr(filter_number_clr),
        .wdata(wdata), .rdata(rdata), .rvalid(rvalid), .end_read(end_read),
        .PE_index(PE_index), .last_PE(last_PE), .last_filter(last_filter),
        .wr_overflow(wr_overflow)
    );

    always #5 clk = ~clk;

    task automatic idle();
        rst = 1'b0; host_wen = 1'b0; host_addr = '0; host_wdata = '0;
        ren_global = 1'b0; wen_global = 1'b0;
        read_addr_en = 1'b0; read_addr_clr = 1'b0;
        write_addr_ld = 1'b0; write_addr_en = 1'b0;
        PE_number_en = 1'b0; PE_number_clr = 1'b0;
        filter_number_en = 1'b0; filter_number_clr = 1'b0;
        wdata = '0;
    endtask

    // One clock edge; the model absorbs the inputs held across it, then settle
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            m_ra = 0; m_wa = 128; m_pe = 0; m_filt = 0;
            m_rdata = '0; m_rvalid = 1'b0; m_ovf = 1'b0;
        end else begin
            m_rvalid = ren_global;
            if (ren_global) m_rdata = m_mem[m_ra];
            if (wen_global) m_mem[m_wa] = wdata;
            else if (host_wen) m_mem[host_addr] = host_wdata;
            if (read_addr_clr) m_ra = 0;
            else if (read_addr_en && m_ra < 127) m_ra = m_ra + 1;
            if (write_addr_ld) m_wa = 128;
            else if (write_addr_en) begin
                if (m_wa == 255) m_ovf = 1'b1;
                else m_wa = m_wa + 1;
            end
            if (PE_number_clr) m_pe = 0;
            else if (PE_number_en) m_pe = (m_pe + 1) % 5;
            if (filter_number_clr) m_filt = 0;
            else if (filter_number_en) m_filt = (m_filt + 1) % 3;
        end
        #1;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1; wen_global = 1'b1; host_wen = 1'b1;
        tick(); tick();
        idle();
        checks++; if (rdata !== 16'd0) begin errors++; $display("FAIL reset_rdata got %0d want 0", rdata); end
        checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid got %0b want 0", rvalid); end
        checks++; if (PE_index !== 3'd0 || last_PE !== 1'b0) begin errors++; $display("FAIL reset_pe got %0d/%0b want 0/0", PE_index, last_PE); end
        checks++; if (end_read !== 1'b0 || last_filter !== 1'b0) begin errors++; $display("FAIL reset_flags got %0b/%0b want 0/0", end_read, last_filter); end
        checks++; if (wr_overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %0b want 0", wr_overflow); end
        checks++; if (dut.write_addr !== 8'd128) begin errors++; $display("FAIL reset_waddr got %0d want 128", dut.write_addr); end
    endtask

    // Fill the whole SRAM so every later read has a known expectation
    task automatic test_preload();
        for (int a = 0; a < 256; a++) begin
            host_wen = 1'b1; host_addr = 8'(a); host_wdata = 16'($urandom);
            tick();
        end
        for (int a = 0; a < 5; a++) begin
            host_addr = 8'(a); host_wdata = 16'(10 + a);
            tick();
        end
        idle();
        checks++; if (dut.mem[3] !== 16'd13) begin errors++; $display("FAIL preload_mem3 got %0d want 13", dut.mem[3]); end
    endtask

    task automatic test_read_stream();
        read_addr_clr = 1'b1; tick(); idle();
        ren_global = 1'b1; read_addr_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (rdata !== 16'(10 + i) || rvalid !== 1'b1) begin
                errors++; $display("FAIL read_stream[%0d] got %0d/%0b want %0d/1", i, rdata, rvalid, 10 + i);
            end
        end
        idle(); tick();
        checks++; if (rvalid !== 1'b0 || rdata !== 16'd14) begin errors++; $display("FAIL read_hold got %0d/%0b want 14/0", rdata, rvalid); end
    endtask

    task automatic test_read_saturate();
        int first_end;
        first_end = -1;
        read_addr_en = 1'b1;
        for (int i = 0; i < 130; i++) begin
            tick();
            if (first_end < 0 && end_read === 1'b1) first_end = i;
        end
        idle();
        // read_addr started at 5, so it reaches 127 after 122 increments
        checks++; if (first_end !== 121) begin errors++; $display("FAIL end_read_first got %0d want 121", first_end); end
        checks++; if (end_read !== 1'b1) begin errors++; $display("FAIL end_read_sticky got %0b want 1", end_read); end
        ren_global = 1'b1; tick(); idle();
        checks++; if (rdata !== m_mem[127]) begin errors++; $display("FAIL read_last got %0h want %0h", rdata, m_mem[127]); end
    endtask

    task automatic test_write();
        write_addr_ld = 1'b1; tick(); idle();
        for (int i = 0; i < 3; i++) begin
            wen_global = 1'b1; write_addr_en = 1'b1; wdata = 16'(16'h100 + i);
            tick();
        end
        idle();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (dut.mem[128 + i] !== 16'(16'h100 + i)) begin
                errors++; $display("FAIL write_mem[%0d] got %0h want %0h", 128 + i, dut.mem[128 + i], 16'h100 + i);
            end
        end
        checks++; if (dut.write_addr !== 8'd131) begin errors++; $display("FAIL write_addr got %0d want 131", dut.write_addr); end
    endtask

    task automatic test_pe_index();
        int exp_pe [6] = '{1, 2, 3, 4, 0, 1};
        PE_number_clr = 1'b1; tick(); idle();
        PE_number_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (PE_index !== 3'(exp_pe[i]) || last_PE !== (exp_pe[i] == 4)) begin
                errors++; $display("FAIL pe_step[%0d] got %0d/%0b want %0d/%0b", i, PE_index, last_PE, exp_pe[i], exp_pe[i] == 4);
            end
        end
        PE_number_clr = 1'b1; tick(); idle();
        checks++; if (PE_index !== 3'd0) begin errors++; $display("FAIL pe_clr_prio got %0d want 0", PE_index); end
    endtask

    task automatic test_filter();
        filter_number_clr = 1'b1; tick(); idle();
        filter_number_en = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            checks++;
            if (last_filter !== ((i % 3) == 2)) begin
                errors++; $display("FAIL filter_step[%0d] got %0b want %0b", i, last_filter, (i % 3) == 2);
            end
        end
        filter_number_clr = 1'b1; tick(); idle();
        checks++; if (last_filter !== 1'b0) begin errors++; $display("FAIL filter_clr_prio got %0b want 0", last_filter); end
    endtask

    task automatic test_overflow();
        write_addr_ld = 1'b1; tick(); idle();
        write_addr_en = 1'b1;
        for (int i = 0; i < 127; i++) tick();
        idle();
        checks++; if (dut.write_addr !== 8'd255 || wr_overflow !== 1'b0) begin errors++; $display("FAIL ovf_top got %0d/%0b want 255/0", dut.write_addr, wr_overflow); end
        write_addr_en = 1'b1; tick(); idle();
        checks++; if (dut.write_addr !== 8'd255 || wr_overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got %0d/%0b want 255/1", dut.write_addr, wr_overflow); end
        wen_global = 1'b1; write_addr_en = 1'b1; wdata = 16'hBEEF; tick(); idle();
        checks++; if (dut.mem[255] !== 16'hBEEF || wr_overflow !== 1'b1) begin errors++; $display("FAIL ovf_write got %0h/%0b want beef/1", dut.mem[255], wr_overflow); end
        rst = 1'b1; tick(); idle();
        checks++; if (dut.write_addr !== 8'd128 || wr_overflow !== 1'b0) begin errors++; $display("FAIL ovf_rst got %0d/%0b want 128/0", dut.write_addr, wr_overflow); end
    endtask

    task automatic test_host_conflict();
        write_addr_en = 1'b1; tick(); tick(); idle();
        host_wen = 1'b1; host_addr = 8'd130; host_wdata = 16'h1111;
        wen_global = 1'b1; wdata = 16'h2222;
        tick(); idle();
        checks++; if (dut.mem[130] !== 16'h2222) begin errors++; $display("FAIL host_conflict got %0h want 2222", dut.mem[130]); end
    endtask

    task automatic test_random();
        int bad;
        bad = 0;
        for (int c = 0; c < 600; c++) begin
            rst               = ($urandom_range(0, 79) == 0);
            host_wen          = $urandom_range(0, 1);
            host_addr         = 8'($urandom);
            host_wdata        = 16'($urandom);
            ren_global        = $urandom_range(0, 1);
            wen_global        = ($urandom_range(0, 3) == 0);
            read_addr_en      = ($urandom_range(0, 3) != 0);
            read_addr_clr     = ($urandom_range(0, 15) == 0);
            write_addr_ld     = ($urandom_range(0, 31) == 0);
            write_addr_en     = $urandom_range(0, 1);
            PE_number_en      = $urandom_range(0, 1);
            PE_number_clr     = ($urandom_range(0, 7) == 0);
            filter_number_en  = $urandom_range(0, 1);
            filter_number_clr = ($urandom_range(0, 7) == 0);
            wdata             = 16'($urandom);
            tick();
            checks++;
            if (rdata !== m_rdata || rvalid !== m_rvalid || end_read !== (m_ra == 127) ||
                PE_index !== 3'(m_pe) || last_PE !== (m_pe == 4) ||
                last_filter !== (m_filt == 2) || wr_overflow !== m_ovf ||
                dut.write_addr !== 8'(m_wa)) begin
                errors++; bad++;
                if (bad <= 10)
                    $display("FAIL random[%0d] rdata %0h/%0h rvalid %0b/%0b end %0b pe %0d/%0d lastf %0b ovf %0b/%0b wa %0d/%0d",
                             c, rdata, m_rdata, rvalid, m_rvalid, end_read, PE_index, m_pe,
                             last_filter, wr_overflow, m_ovf, dut.write_addr, m_wa);
            end
        end
        idle();
        for (int a = 0; a < 256; a++) begin
            checks++;
            if (dut.mem[a] !== m_mem[a]) begin
                errors++; $display("FAIL random_mem[%0d] got %0h want %0h", a, dut.mem[a], m_mem[a]);
            end
        end
    endtask

    initial begin
        idle();
        rst = 1'b1;
        test_reset();
        test_preload();
        test_read_stream();
        test_read_saturate();
        test_write();
        test_pe_index();
        test_filter();
        test_overflow();
        test_host_conflict();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
